// File: rtl/gpr_writeback_arbiter_pkg.sv
// Shared types and constants for the GPR writeback arbiter and its queues.
package gpr_writeback_arbiter_pkg;

  localparam int GPR_IDX_SIZE = 5;
  localparam int GPR_SIZE     = 32;
  localparam int GPR_NUM      = 32;

  // Requester indices: ALU/EX result and load/MEM result.
  localparam int WB_REQ_ALU  = 0;
  localparam int WB_REQ_LOAD = 1;

  // Address lookups each queue answers: two decode read ports and the
  // address currently offered by the other requester.
  localparam int NUM_LOOKUP = 3;
  localparam int LK_RD1     = 0;
  localparam int LK_RD2     = 1;
  localparam int LK_OTHER   = 2;

  typedef logic [GPR_IDX_SIZE-1:0] gpr_idx_t;
  typedef logic [GPR_SIZE-1:0]     gpr_data_t;

  typedef struct packed {
    gpr_idx_t  addr;
    gpr_data_t data;
  } wb_entry_t;

  // r0 is hardwired to zero, so it never counts as a pending write.
  function automatic logic addr_hit(input gpr_idx_t a, input gpr_idx_t b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/gpr_writeback_arbiter_wb_queue.sv
// wb_queue: small FIFO of {addr,data} writeback entries with per-entry
// valid flags and address-match lookups used for hazard and busy detection.
module gpr_writeback_arbiter_wb_queue
  import gpr_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic                                    push,
  input  wb_entry_t                               push_entry,
  input  logic                                    pop,
  output logic                                    full,
  output logic                                    empty,
  output wb_entry_t                               head_entry,
  output logic [DEPTH-1:0]                        entry_valid,
  input  logic [NUM_LOOKUP-1:0][GPR_IDX_SIZE-1:0] lookup_addr,
  output logic [NUM_LOOKUP-1:0]                   lookup_hit
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;
  logic [PW:0] count;
  wb_entry_t   mem_reg [DEPTH];

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign head_entry = mem_reg[rd_ptr_reg[PW-1:0]];

  // Pointer update; the arbiter never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg[PW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_reg[PW-1:0];
    assign entry_valid[gi] = ({1'b0, offset} < count);
  end

  // Each lookup hits when any live entry targets that (non-zero) register.
  for (genvar gi = 0; gi < NUM_LOOKUP; gi++) begin : g_lookup
    logic [DEPTH-1:0] eq;
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_eq
      assign eq[gj] = (mem_reg[gj].addr == lookup_addr[gi]);
    end
    assign lookup_hit[gi] = (lookup_addr[gi] != '0) && |(eq & entry_valid);
  end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Shares the single register-file write port between the ALU (REQ0) and
// load (REQ1) writeback paths, keeps same-register writes in acceptance
// order, and reports per-read-port busy flags to decode.
module gpr_writeback_arbiter
  import gpr_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    req0_valid_i,
  input  logic [GPR_IDX_SIZE-1:0] req0_addr_i,
  input  logic [GPR_SIZE-1:0]     req0_data_i,
  output logic                    req0_ready_o,
  input  logic                    req1_valid_i,
  input  logic [GPR_IDX_SIZE-1:0] req1_addr_i,
  input  logic [GPR_SIZE-1:0]     req1_data_i,
  output logic                    req1_ready_o,
  input  logic [GPR_IDX_SIZE-1:0] rd1_addr_i,
  input  logic [GPR_IDX_SIZE-1:0] rd2_addr_i,
  output logic                    rd1_busy_o,
  output logic                    rd2_busy_o,
  output logic                    register_write_o,
  output logic [GPR_IDX_SIZE-1:0] register_write_addr_o,
  output logic [GPR_SIZE-1:0]     register_write_data_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t              req_entry   [2];
  wb_entry_t              q_head      [2];
  logic [DEPTH-1:0]       q_entry_valid [2];
  logic [NUM_LOOKUP-1:0]  q_hit       [2];
  logic [1:0]             q_full;
  logic [1:0]             q_empty;
  logic [1:0]             q_push;
  logic [1:0]             q_pop;

  logic ready0, ready1, waw0, waw1;
  logic grant_alu, grant_load;

  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic          out_valid_reg, out_valid_next;
  gpr_idx_t      out_addr_reg, out_addr_next;
  gpr_data_t     out_data_reg, out_data_next;

  assign req_entry[WB_REQ_ALU]  = '{addr: req0_addr_i, data: req0_data_i};
  assign req_entry[WB_REQ_LOAD] = '{addr: req1_addr_i, data: req1_data_i};

  // One queue per requester; each also checks the other requester's address.
  for (genvar gi = 0; gi < 2; gi++) begin : g_queue
    logic [NUM_LOOKUP-1:0][GPR_IDX_SIZE-1:0] lookup;
    assign lookup = {req_entry[1-gi].addr, rd2_addr_i, rd1_addr_i};

    gpr_writeback_arbiter_wb_queue #(.DEPTH(DEPTH)) u_wb_queue (
      .clk         (clock_i),
      .srst        (reset_i),
      .push        (q_push[gi]),
      .push_entry  (req_entry[gi]),
      .pop         (q_pop[gi]),
      .full        (q_full[gi]),
      .empty       (q_empty[gi]),
      .head_entry  (q_head[gi]),
      .entry_valid (q_entry_valid[gi]),
      .lookup_addr (lookup),
      .lookup_hit  (q_hit[gi])
    );
  end

  // Acceptance: a request stalls if an older write to the same register is
  // still in the other queue or the output stage. On a same-cycle tie the
  // ALU request wins and the load request waits. r0 is accepted but dropped.
  always_comb begin
    waw0   = q_hit[WB_REQ_LOAD][LK_OTHER]
           || (out_valid_reg && addr_hit(req0_addr_i, out_addr_reg));
    ready0 = !reset_i && !q_full[WB_REQ_ALU] && !waw0;
    waw1   = q_hit[WB_REQ_ALU][LK_OTHER]
           || (out_valid_reg && addr_hit(req1_addr_i, out_addr_reg))
           || (req0_valid_i && ready0 && addr_hit(req1_addr_i, req0_addr_i));
    ready1 = !reset_i && !q_full[WB_REQ_LOAD] && !waw1;
    q_push = {req1_valid_i && ready1 && (req1_addr_i != '0),
              req0_valid_i && ready0 && (req0_addr_i != '0)};
  end

  // Grant one head per cycle: ALU by default, load when starved or alone.
  always_comb begin
    grant_load = !reset_i && !q_empty[WB_REQ_LOAD]
               && ((starve_cnt_reg == SW'(STARVE_LIMIT)) || q_empty[WB_REQ_ALU]);
    grant_alu  = !reset_i && !q_empty[WB_REQ_ALU] && !grant_load;
    q_pop      = {grant_load, grant_alu};

    out_valid_next = grant_alu || grant_load;
    out_addr_next  = '0;
    out_data_next  = '0;
    if (grant_load) begin
      out_addr_next = q_head[WB_REQ_LOAD].addr;
      out_data_next = q_head[WB_REQ_LOAD].data;
    end else if (grant_alu) begin
      out_addr_next = q_head[WB_REQ_ALU].addr;
      out_data_next = q_head[WB_REQ_ALU].data;
    end

    // Count cycles a waiting load head is passed over; saturate at the limit.
    starve_cnt_next = '0;
    if (|q_entry_valid[WB_REQ_LOAD] && !grant_load) begin
      starve_cnt_next = (starve_cnt_reg == SW'(STARVE_LIMIT))
                      ? starve_cnt_reg : starve_cnt_reg + 1'b1;
    end
  end

  // Output stage and starvation counter, reloaded every cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_reg  <= 1'b0;
      out_addr_reg   <= '0;
      out_data_reg   <= '0;
      starve_cnt_reg <= '0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_addr_reg   <= out_addr_next;
      out_data_reg   <= out_data_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    req0_ready_o          = ready0;
    req1_ready_o          = ready1;
    register_write_o      = !reset_i && out_valid_reg;
    register_write_addr_o = reset_i ? '0 : out_addr_reg;
    register_write_data_o = reset_i ? '0 : out_data_reg;
    rd1_busy_o = !reset_i && (q_hit[WB_REQ_ALU][LK_RD1] || q_hit[WB_REQ_LOAD][LK_RD1]
               || (out_valid_reg && addr_hit(rd1_addr_i, out_addr_reg)));
    rd2_busy_o = !reset_i && (q_hit[WB_REQ_ALU][LK_RD2] || q_hit[WB_REQ_LOAD][LK_RD2]
               || (out_valid_reg && addr_hit(rd2_addr_i, out_addr_reg)));
  end

endmodule
